// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : panel_pkg
//  Description : Shared constants for the front-panel key arbiter: FSM state
//                encoding, synchronizer depth and default debounce length.
//  Revision    : 1.0 - initial release
// ============================================================================
package panel_pkg;

    localparam int unsigned c_SYNC_DEPTH              = 3;
    localparam int unsigned c_DEBOUNCE_CYCLES_DEFAULT = 50000;

    localparam int unsigned         c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_IDLE   = 1'b0;
    localparam logic [c_STATE_W-1:0] c_OFFER  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Multi-flop synchronizer for asynchronous level inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Stage 0 is the metastability-exposed flop; DEPTH must be at least 2.
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[DEPTH-2:0], i_data};
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/panel_key_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : panel_key_arbiter
//  Description : Synchronizes and debounces front-panel keys, records accepted
//                presses and offers them round-robin over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module panel_key_arbiter
    import panel_pkg::*;
#(
    parameter int unsigned N_KEYS          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_KEYS-1:0]         key_raw,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [$clog2(N_KEYS)-1:0] cmd_key,
    output logic [N_KEYS-1:0]         pending,
    output logic                      overrun,
    input  logic                      ovr_clear
);

    localparam int unsigned          c_KEY_W   = $clog2(N_KEYS);
    localparam int unsigned          c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_KEY_W-1:0]   c_LAST_RST = c_KEY_W'(N_KEYS - 1);

    logic                  w_resetn;
    logic [N_KEYS-1:0]     w_sync;
    logic [N_KEYS-1:0]     r_deb;
    logic [N_KEYS-1:0]     r_deb_d;
    logic [c_CNT_W-1:0]    r_cnt [N_KEYS];
    logic [N_KEYS-1:0]     w_press;

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_state_nxt;
    logic                  w_offer;
    logic                  w_handshake;
    logic                  w_load_key;

    logic [c_KEY_W-1:0]    r_cmd_key;
    logic [c_KEY_W-1:0]    r_last_grant;
    logic [N_KEYS-1:0]     r_pending;
    logic                  r_overrun;

    logic [N_KEYS-1:0]     w_hs_mask;
    logic [N_KEYS-1:0]     w_pending_nxt;
    logic                  w_ovr_set;
    logic                  w_found;
    logic [c_KEY_W-1:0]    w_pick;
    logic [c_KEY_W-1:0]    w_cand;
    int unsigned           w_idx;

    assign w_resetn = ~reset;

    sync_chain #(
        .WIDTH (N_KEYS),
        .DEPTH (c_SYNC_DEPTH)
    ) u_sync (
        .clk    (clk),
        .resetn (w_resetn),
        .i_data (key_raw),
        .o_data (w_sync)
    );

    // Per-key debounce: the counter only runs while the synchronized level
    // disagrees with the accepted level; a single agreeing cycle restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int k = 0; k < int'(N_KEYS); k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_deb_d <= r_deb;
            for (int k = 0; k < int'(N_KEYS); k++) begin
                if (w_sync[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == c_CNT_MAX) begin
                    r_cnt[k] <= '0;
                    r_deb[k] <= w_sync[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_deb & ~r_deb_d;

    // Round-robin search starting just after the last granted key.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= N_KEYS; k++) begin
            w_idx  = (32'(r_last_grant) + k) % N_KEYS;
            w_cand = c_KEY_W'(w_idx);
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found)     w_state_nxt = c_OFFER;
            c_OFFER: if (w_handshake) w_state_nxt = c_IDLE;
            default:                  w_state_nxt = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_offer     = (r_state == c_OFFER);
        w_handshake = w_offer && cmd_ready;
        w_load_key  = (r_state == c_IDLE) && w_found;
    end

    // A press landing on the key being accepted re-arms it rather than
    // counting as a lost press.
    always_comb begin
        w_hs_mask = '0;
        if (w_handshake) begin
            w_hs_mask[r_cmd_key] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_hs_mask) | w_press;
        w_ovr_set     = |(w_press & r_pending & ~w_hs_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_key    <= '0;
            r_last_grant <= c_LAST_RST;
            r_pending    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load_key) begin
                r_cmd_key <= w_pick;
            end
            if (w_handshake) begin
                r_last_grant <= r_cmd_key;
            end
            r_pending <= w_pending_nxt;
            r_overrun <= w_ovr_set | (r_overrun & ~ovr_clear);
        end
    end

    assign cmd_valid = w_offer;
    assign cmd_key   = r_cmd_key;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_panel_key_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_panel_key_arbiter
//  Description : Directed self-checking bench for panel_key_arbiter
//                (N_KEYS=4, DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_key_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_raw;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_key;
    logic [3:0] pending;
    logic       overrun;
    logic       ovr_clear;

    int n_vec = 0;
    int n_err = 0;
    int unsigned hs_q[$];

    int e_valid [6] = '{1, 0, 1, 0, 1, 0};
    int e_key   [6] = '{0, 0, 1, 0, 3, 0};
    int e_pend  [6] = '{4'b1011, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};

    always #5 clk = ~clk;

    panel_key_arbiter #(
        .N_KEYS          (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (key_raw),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_key   (cmd_key),
        .pending   (pending),
        .overrun   (overrun),
        .ovr_clear (ovr_clear)
    );

    // Handshake log, sampled with the pre-edge values the DUT itself sees.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) hs_q.push_back(32'(cmd_key));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        key_raw   = '0;
        cmd_ready = 1'b0;
        ovr_clear = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        hs_q.delete();
    endtask

    initial begin
        int unsigned any_seen;
        reset     = 1'b1;
        key_raw   = '0;
        cmd_ready = 1'b0;
        ovr_clear = 1'b0;
        tick(2);
        check_vec("rst_valid",   32'(cmd_valid), 0);
        check_vec("rst_key",     32'(cmd_key),   0);
        check_vec("rst_pending", 32'(pending),   0);
        check_vec("rst_overrun", 32'(overrun),   0);
        reset = 1'b0;
        tick(1);
        hs_q.delete();

        // Single key, consumer always ready: offer rises 9 edges after press.
        key_raw[2] = 1'b1;
        cmd_ready  = 1'b1;
        tick(8);
        check_vec("lat_valid_e8",   32'(cmd_valid), 0);
        check_vec("lat_pending_e8", 32'(pending),   4'b0100);
        tick(1);
        check_vec("lat_valid_e9",   32'(cmd_valid), 1);
        check_vec("lat_key_e9",     32'(cmd_key),   2);
        tick(1);
        check_vec("lat_valid_e10",   32'(cmd_valid), 0);
        check_vec("lat_pending_e10", 32'(pending),   0);
        tick(10);
        key_raw[2] = 1'b0;
        tick(15);
        check_vec("lat_hs_count", hs_q.size(), 1);
        if (hs_q.size() > 0) check_vec("lat_hs_key", hs_q[0], 2);

        // Glitch one cycle shorter than the debounce window.
        do_reset();
        cmd_ready  = 1'b1;
        key_raw[1] = 1'b1;
        tick(3);
        key_raw[1] = 1'b0;
        any_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (cmd_valid || (pending != 0)) any_seen++;
        end
        check_vec("glitch_activity", any_seen, 0);
        check_vec("glitch_pending",  32'(pending), 0);

        // Three simultaneous presses, round-robin from reset.
        do_reset();
        cmd_ready = 1'b1;
        key_raw   = 4'b1011;
        tick(8);
        check_vec("rr_pending_e8", 32'(pending), 4'b1011);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_vec($sformatf("rr_valid_%0d", i), 32'(cmd_valid), 32'(e_valid[i]));
            if (e_valid[i] != 0) check_vec($sformatf("rr_key_%0d", i), 32'(cmd_key), 32'(e_key[i]));
            check_vec($sformatf("rr_pend_%0d", i), 32'(pending), 32'(e_pend[i]));
        end
        check_vec("rr_hs_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check_vec("rr_hs0", hs_q[0], 0);
            check_vec("rr_hs1", hs_q[1], 1);
            check_vec("rr_hs2", hs_q[2], 3);
        end
        key_raw = '0;
        tick(12);

        // Back-pressure: offer must hold steady.
        do_reset();
        key_raw[3] = 1'b1;
        tick(9);
        for (int i = 0; i < 10; i++) begin
            check_vec($sformatf("bp_valid_%0d", i), 32'(cmd_valid), 1);
            check_vec($sformatf("bp_key_%0d", i),   32'(cmd_key),   3);
            tick(1);
        end
        cmd_ready = 1'b1;
        tick(1);
        check_vec("bp_valid_after", 32'(cmd_valid), 0);
        check_vec("bp_pending",     32'(pending),   0);
        tick(4);
        check_vec("bp_hs_count", hs_q.size(), 1);

        // Lost press: release and re-press while still pending.
        do_reset();
        key_raw[2] = 1'b1;
        tick(12);
        key_raw[2] = 1'b0;
        tick(12);
        check_vec("ovr_before_repress", 32'(overrun), 0);
        key_raw[2] = 1'b1;
        tick(7);
        check_vec("ovr_not_yet", 32'(overrun), 0);
        ovr_clear = 1'b1;
        tick(1);
        ovr_clear = 1'b0;
        check_vec("ovr_set_wins_clear", 32'(overrun),   1);
        check_vec("ovr_pending",        32'(pending),   4'b0100);
        check_vec("ovr_valid",          32'(cmd_valid), 1);
        check_vec("ovr_key",            32'(cmd_key),   2);
        tick(3);
        cmd_ready = 1'b1;
        tick(1);
        check_vec("ovr_hs_valid",   32'(cmd_valid), 0);
        check_vec("ovr_hs_pending", 32'(pending),   0);
        tick(5);
        check_vec("ovr_no_second", 32'(cmd_valid), 0);
        check_vec("ovr_hs_count",  hs_q.size(),    1);
        check_vec("ovr_sticky",    32'(overrun),   1);
        ovr_clear = 1'b1;
        tick(1);
        ovr_clear = 1'b0;
        check_vec("ovr_cleared", 32'(overrun), 0);

        // Re-press landing exactly on the handshake of the same key.
        do_reset();
        key_raw[2] = 1'b1;
        tick(10);
        key_raw[2] = 1'b0;
        tick(10);
        key_raw[2] = 1'b1;
        tick(7);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check_vec("hsp_valid",   32'(cmd_valid), 0);
        check_vec("hsp_pending", 32'(pending),   4'b0100);
        check_vec("hsp_overrun", 32'(overrun),   0);
        tick(1);
        check_vec("hsp_reoffer",     32'(cmd_valid), 1);
        check_vec("hsp_reoffer_key", 32'(cmd_key),   2);

        // Asynchronous reset in the middle of an offer.
        do_reset();
        key_raw[1] = 1'b1;
        tick(9);
        check_vec("ar_offer", 32'(cmd_valid), 1);
        reset   = 1'b1;
        key_raw = '0;
        #1;
        check_vec("ar_valid_async",   32'(cmd_valid), 0);
        check_vec("ar_pending_async", 32'(pending),   0);
        tick(1);
        reset = 1'b0;
        tick(1);
        key_raw[0] = 1'b1;
        tick(8);
        check_vec("ar_pending_new", 32'(pending), 4'b0001);
        tick(1);
        check_vec("ar_valid_new", 32'(cmd_valid), 1);
        check_vec("ar_key_new",   32'(cmd_key),   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/panel_key_arbiter.md
PANEL_KEY_ARBITER -- requirements
Module: panel_key_arbiter

Interface
REQ-001 Parameter N_KEYS, default 8, SHALL set the number of front-panel keys (2..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the stable-level cycles required to accept a key level change (>=2).
REQ-003 clk  in  1  SHALL be the single clock; all state is on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 key_raw  in  N_KEYS  SHALL carry asynchronous, bouncing pushbutton levels, with 1 meaning pressed.
REQ-006 cmd_valid  out  1  SHALL indicate that a key command is offered.
REQ-007 cmd_ready  in  1  SHALL indicate that the consumer accepts the command.
REQ-008 cmd_key  out  clog2(N_KEYS)  SHALL carry the index of the offered key.
REQ-009 pending  out  N_KEYS  SHALL carry the per-key accepted-press-awaiting-service flags.
REQ-010 overrun  out  1  SHALL be a sticky flag: a press was lost because that key was already pending.
REQ-011 ovr_clear  in  1  SHALL clear overrun synchronously.

Function
REQ-012 Each key_raw bit SHALL pass through a 3-flop synchronizer, giving 3 cycles of latency, before any other logic.
REQ-013 Each key SHALL have a debounced level deb[i], changed only after the synchronized level has differed from deb[i] for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL zero the counter.
REQ-014 Release SHALL be debounced symmetrically; release SHALL generate no command.
REQ-015 A deb[i] 0->1 transition SHALL set pending[i] on the next edge.
REQ-016 A press event on a key already pending and not being accepted that cycle SHALL set overrun; pending[i] stays 1 and no second command is queued.
REQ-017 The FSM SHALL have states IDLE and OFFER; cmd_valid = (state==OFFER).
REQ-018 In IDLE with any pending bit set, the FSM SHALL pick the first pending index strictly after last_grant (round-robin, wrapping at N_KEYS-1 to 0), latch it into cmd_key, and enter OFFER.
REQ-019 In IDLE with no pending bits set, the FSM SHALL stay in IDLE.
REQ-020 In OFFER, cmd_key SHALL hold stable until cmd_valid && cmd_ready.
REQ-021 On a handshake, the block SHALL clear pending[cmd_key], set last_grant = cmd_key, and return to IDLE, giving at least one idle cycle between commands.
REQ-022 A press event on key cmd_key in the handshake cycle SHALL leave pending[cmd_key] set and SHALL NOT set overrun.
REQ-023 cmd_valid SHALL never drop without a handshake, except on reset.
REQ-024 ovr_clear and a new overrun in the same cycle SHALL leave overrun = 1.
REQ-025 End-to-end latency from the first edge that samples a stable high key_raw to cmd_valid=1 SHALL be 3 + DEBOUNCE_CYCLES + 2 cycles, when the FSM is idle and nothing else is pending.

Reset
REQ-026 On reset, cmd_valid, cmd_key, pending, overrun, deb, the counters and the synchronizer flops SHALL be 0, the state IDLE, and last_grant N_KEYS-1, so key 0 has first priority.
REQ-027 Reset asserted mid-OFFER SHALL drop cmd_valid immediately (asynchronously) and discard all pending presses.

Structure
REQ-028 A shared package panel_pkg SHALL hold the FSM state encoding (IDLE, OFFER), the synchronizer depth constant (3) and the default DEBOUNCE_CYCLES.
REQ-029 The synchronizer SHALL be the existing sync_chain sub-module, instantiated once with width N_KEYS and resetn driven by ~reset; debounce and arbitration logic SHALL be in this module.

Verification (N_KEYS=4, DEBOUNCE_CYCLES=4, unless noted)
REQ-030 key_raw[2] high for 20 cycles, cmd_ready=1 -> exactly one cmd_valid pulse with cmd_key=2, rising 9 cycles after the first sampling edge.
REQ-031 key_raw[1] high for 3 cycles, then low -> no cmd_valid, pending stays 0.
REQ-032 Keys 0, 1 and 3 pressed in the same cycle, cmd_ready=1 -> commands in order 0, 1, 3, each separated by one idle cycle, and pending ends at 0.
REQ-033 Key 3 pressed, cmd_ready=0 for 10 cycles then 1 -> cmd_valid and cmd_key=3 stable for all 10 cycles, then exactly one handshake.
REQ-034 Key 2 pending, then released and re-pressed (both debounced) before acceptance -> overrun=1 and one command only; ovr_clear pulse -> overrun=0.
REQ-035 Reset asserted for 1 cycle during OFFER -> cmd_valid=0 before the next edge, pending=0, and the next grant after a new press of key 0 is cmd_key=0.
